variable_bound_solver: RTL and testbench
========================================

Name: variable_bound_solver

Overview:
- Inverse of the clause checker. The checker asks "does assignment y satisfy a1*y1+a2*y2+..+aN <= 0?". This block asks "given the clause and all other variables, which values of the selected variable y_k satisfy it?"
- It returns an inclusive signed interval [lower, upper] clamped to the variable width, or an empty flag.
- It feeds the MCMC proposal stage, which samples y_k inside the interval.
- It is sequential: an iterative multiply-accumulate followed by a restoring divider, with a start/done handshake.

Parameters:
NUM_VARS, 2, number of integer variables per clause
WIDTH, 8, bit width of each coefficient and variable (signed two's complement)
IDX_W, 1, width of the variable-select index; must be at least clog2(NUM_VARS)

Ports:
in_clk  input  1  clock, rising edge
in_reset  input  1  asynchronous, active-low reset (0 = reset)
in_start  input  1  request a solve; sampled only in IDLE
in_coefficients  input  (NUM_VARS+1)*WIDTH  clause coefficients; a_i at [i*WIDTH +: WIDTH], constant a_N at index NUM_VARS
in_current_assignment  input  NUM_VARS*WIDTH  current values y_i at [i*WIDTH +: WIDTH]
in_var_index  input  IDX_W  selected variable k, valid range 0..NUM_VARS-1
out_lower  output  WIDTH  signed lower bound of y_k
out_upper  output  WIDTH  signed upper bound of y_k
out_empty  output  1  no value of y_k in WIDTH range satisfies the clause
out_busy  output  1  high from the cycle after start acceptance until done
out_done  output  1  one-cycle pulse; outputs valid from this cycle on

Behaviour:
- Reset (in_reset=0, asynchronous): state=IDLE; out_lower=0, out_upper=0, out_empty=0, out_busy=0, out_done=0. Reset mid-solve aborts with no done pulse.
- Internal accumulator width: AW = 2*WIDTH + clog2(NUM_VARS+1), signed. All products are sign-extended to AW.
- States: IDLE -> ACCUM -> DIVIDE -> FIX -> DONE -> IDLE.
- IDLE:
  - On in_start=1, register the coefficients, the assignment and k; set R = sign-extended a_N; go to ACCUM.
  - An out-of-range k (k >= NUM_VARS) gives out_empty=1 and goes directly to DONE.
- ACCUM: one index i per cycle, i = 0..NUM_VARS-1. If i != k, add a_i*y_i to R. Lasts NUM_VARS cycles.
- DIVIDE, constraint is a_k*y_k <= -R:
  - If a_k == 0, skip to FIX.
  - Otherwise run an unsigned restoring division of |R| by |a_k|, one quotient bit per cycle, AW cycles. Produces quotient q and remainder rem.
- FIX, one cycle. Compute the exact bound as an AW-bit value, then clamp to [MIN, MAX] = [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - a_k > 0: upper = floor(-R/a_k), which is q if R <= 0, else -(q + (rem != 0)). lower = MIN. out_empty = 1 if upper < MIN.
  - a_k < 0: lower = ceil(R/|a_k|), which is q + (rem != 0) if R >= 0, else -q. upper = MAX. out_empty = 1 if lower > MAX.
  - a_k == 0: R <= 0 gives [MIN, MAX] with out_empty=0. Otherwise out_empty=1.
  - Whenever out_empty=1: out_lower=MAX and out_upper=MIN.
- DONE: out_done=1 for exactly one cycle and out_busy=0; return to IDLE. Outputs hold until the next accepted start.
- Latency, start-accept edge to out_done high:
  - Normal: NUM_VARS + AW + 2 cycles (22 at the defaults).
  - a_k == 0: NUM_VARS + 2 cycles.
- in_start while busy is ignored. Inputs need only be stable on the accepting edge.
- Back-to-back: in_start high in the DONE cycle is not accepted. It is accepted on the next IDLE cycle.

Optional Feature:
- Macro: SOLVER_CURRENT_OK_EN.
- Defined: adds output out_current_ok (1 bit, reset 0), updated in FIX. It equals 1 when the registered current y_k lies within [out_lower, out_upper] and out_empty=0. This is identical to the checker's satisfied flag for the same clause.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Defaults, clause 3*y0+2*y1-10, y1=2, k=0 -> R=-6; out_upper=2, out_lower=-128, out_empty=0; out_done exactly 22 cycles after start.
- Clause -4*y0+1*y1+5, y1=3, k=0 -> R=8; out_lower=2, out_upper=127. Clause 3*y0+0*y1+7, k=0 -> out_upper=-3 (floor of -7/3).
- a_k=0, clause 0*y0+1*y1-5, k=0: y1=2 -> [-128,127], out_empty=0, done after 4 cycles; y1=9 -> out_empty=1, out_lower=127, out_upper=-128.
- Clamp/empty: 1*y0+100*y1+0, y1=-100 -> out_upper=127 (clamped from 10000); y1=100 -> upper=-10000 < -128 -> out_empty=1.
- Reset low at cycle 10 of a solve -> all outputs 0 immediately, no done pulse. in_start pulsed while busy -> ignored, exactly one done pulse.
- With SOLVER_CURRENT_OK_EN: first case with y0=2 -> out_current_ok=1; y0=3 -> out_current_ok=0.

Source files
------------

// File: rtl/variable_bound_solver_if.sv
// ---------------------------------------------------------------------------
// variable_bound_solver_if
//   Request/response bundle for variable_bound_solver.
//   Request  : in_start, in_coefficients ({a_N, .., a_1, a_0}, WIDTH bits each),
//              in_current_assignment ({y_(N-1), .., y_0}), in_var_index (k).
//   Response : out_lower, out_upper (signed interval for y_k), out_empty,
//              out_busy, out_done, and out_current_ok when the build defines
//              SOLVER_CURRENT_OK_EN.
//   master drives the request side; slave is the solver.
// ---------------------------------------------------------------------------
interface variable_bound_solver_if #(
  parameter int NUM_VARS = 2,
  parameter int WIDTH    = 8,
  parameter int IDX_W    = 1
);
  logic                            in_start;
  logic [(NUM_VARS+1)*WIDTH-1:0]   in_coefficients;
  logic [NUM_VARS*WIDTH-1:0]       in_current_assignment;
  logic [IDX_W-1:0]                in_var_index;
  logic [WIDTH-1:0]                out_lower;
  logic [WIDTH-1:0]                out_upper;
  logic                            out_empty;
  logic                            out_busy;
  logic                            out_done;
`ifdef SOLVER_CURRENT_OK_EN
  logic                            out_current_ok;

  modport master (
    output in_start, in_coefficients, in_current_assignment, in_var_index,
    input  out_lower, out_upper, out_empty, out_busy, out_done, out_current_ok
  );
  modport slave (
    input  in_start, in_coefficients, in_current_assignment, in_var_index,
    output out_lower, out_upper, out_empty, out_busy, out_done, out_current_ok
  );
`else
  modport master (
    output in_start, in_coefficients, in_current_assignment, in_var_index,
    input  out_lower, out_upper, out_empty, out_busy, out_done
  );
  modport slave (
    input  in_start, in_coefficients, in_current_assignment, in_var_index,
    output out_lower, out_upper, out_empty, out_busy, out_done
  );
`endif
endinterface

// File: rtl/variable_bound_solver.sv
// ---------------------------------------------------------------------------
// variable_bound_solver
//   For the clause a_0*y_0 + .. + a_(N-1)*y_(N-1) + a_N <= 0, computes the
//   inclusive signed interval of y_k that satisfies it with every other y_i
//   held at its current value, clamped to the WIDTH-bit range, or flags it
//   empty. Sequence: ACCUM (one MAC per cycle) -> DIVIDE (restoring divider,
//   one quotient bit per cycle) -> FIX (rounding + clamp) -> DONE pulse.
// Ports
//   in_clk    : clock, rising edge
//   in_reset  : asynchronous active-low reset
//   bus       : variable_bound_solver_if.slave (start/operands in, bounds out)
// Build option
//   SOLVER_CURRENT_OK_EN : adds out_current_ok, set when the registered y_k
//                          already lies inside the non-empty interval.
// ---------------------------------------------------------------------------
module variable_bound_solver #(
  parameter int NUM_VARS = 2,
  parameter int WIDTH    = 8,
  parameter int IDX_W    = 1
) (
  input  logic                         in_clk,
  input  logic                         in_reset,
  variable_bound_solver_if.slave       bus
);
  localparam int AW = 2*WIDTH + $clog2(NUM_VARS+1);  // accumulator width
  localparam int BW = AW + 1;                        // room for the signed bound
  localparam int CW = $clog2(AW);                    // divider step counter
  localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [BW-1:0]    MIN_B = BW'(MIN_W);
  localparam logic signed [BW-1:0]    MAX_B = BW'(MAX_W);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DIVIDE, S_FIX, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [WIDTH-1:0]  a_q [NUM_VARS];
  logic signed [WIDTH-1:0]  a_d [NUM_VARS];
  logic signed [WIDTH-1:0]  y_q [NUM_VARS];
  logic signed [WIDTH-1:0]  y_d [NUM_VARS];
  logic [IDX_W-1:0]         k_q, k_d, idx_q, idx_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     div_run_q, div_run_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [AW-1:0]            quo_q, quo_d, rem_q, rem_d;
  logic [WIDTH-1:0]         dvs_q, dvs_d;
  logic signed [WIDTH-1:0]  lower_q, lower_d, upper_q, upper_d;
  logic                     empty_q, empty_d;

  logic signed [WIDTH-1:0]  a_k, y_k;
  logic signed [2*WIDTH-1:0] prod;
  logic [AW-1:0]            abs_r, rem_sh, dvs_ext;
  logic signed [BW-1:0]     q_s, q_c, bnd;
  logic signed [WIDTH-1:0]  fix_lo, fix_up;
  logic                     fix_emp;

  assign a_k     = a_q[k_q];
  assign y_k     = y_q[k_q];
  assign prod    = (2*WIDTH)'(a_q[idx_q]) * (2*WIDTH)'(y_q[idx_q]);
  assign abs_r   = acc_q[AW-1] ? unsigned'(-acc_q) : unsigned'(acc_q);
  assign rem_sh  = {rem_q[AW-2:0], quo_q[AW-1]};
  assign dvs_ext = {{(AW-WIDTH){1'b0}}, dvs_q};
  assign q_s     = signed'({1'b0, quo_q});
  assign q_c     = q_s + ((|rem_q) ? BW'(1) : BW'(0));   // q rounded away from zero

  // Exact bound from |R|/|a_k|, then clamp. floor(-R/a) for a>0 and
  // ceil(R/|a|) for a<0 differ from q only when the rounding crosses zero.
  always_comb begin : fix_math
    bnd     = '0;
    fix_emp = 1'b0;
    fix_lo  = MIN_W;
    fix_up  = MAX_W;
    if (a_k == '0) begin
      fix_emp = (acc_q > 0);
    end else if (!a_k[WIDTH-1]) begin
      bnd = (acc_q <= 0) ? q_s : -q_c;
      if (bnd < MIN_B)      fix_emp = 1'b1;
      else if (bnd < MAX_B) fix_up  = WIDTH'(bnd);
    end else begin
      bnd = (acc_q >= 0) ? q_c : -q_s;
      if (bnd > MAX_B)      fix_emp = 1'b1;
      else if (bnd > MIN_B) fix_lo  = WIDTH'(bnd);
    end
    if (fix_emp) begin
      fix_lo = MAX_W;
      fix_up = MIN_W;
    end
  end

`ifdef SOLVER_CURRENT_OK_EN
  logic ok_q, ok_d;
  assign bus.out_current_ok = ok_q;
`endif

  always_comb begin : next_state
    // NOTE: every _d takes its held value first, so no branch can leave one unassigned and infer a latch.
    state_d   = state_q;
    a_d       = a_q;
    y_d       = y_q;
    k_d       = k_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    div_run_d = div_run_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    lower_d   = lower_q;
    upper_d   = upper_q;
    empty_d   = empty_q;
`ifdef SOLVER_CURRENT_OK_EN
    ok_d      = ok_q;
`endif
    unique case (state_q)
      S_IDLE: if (bus.in_start) begin
        for (int i = 0; i < NUM_VARS; i++) begin
          a_d[i] = bus.in_coefficients[i*WIDTH +: WIDTH];
          y_d[i] = bus.in_current_assignment[i*WIDTH +: WIDTH];
        end
        k_d   = bus.in_var_index;
        idx_d = '0;
        acc_d = AW'(signed'(bus.in_coefficients[NUM_VARS*WIDTH +: WIDTH]));
        if (32'(bus.in_var_index) >= NUM_VARS) begin
          empty_d = 1'b1;
          lower_d = MAX_W;
          upper_d = MIN_W;
`ifdef SOLVER_CURRENT_OK_EN
          ok_d    = 1'b0;
`endif
          state_d = S_DONE;
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (idx_q != k_q) acc_d = acc_q + AW'(prod);
        idx_d = idx_q + IDX_W'(1);
        if (32'(idx_q) == NUM_VARS - 1) begin
          cnt_d     = '0;
          div_run_d = 1'b0;
          state_d   = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (!div_run_q) begin
          // Setup cycle: latch magnitudes; a zero a_k needs no division.
          if (a_k == '0) begin
            state_d = S_FIX;
          end else begin
            quo_d     = abs_r;
            rem_d     = '0;
            dvs_d     = a_k[WIDTH-1] ? unsigned'(-a_k) : unsigned'(a_k);
            cnt_d     = '0;
            div_run_d = 1'b1;
          end
        end else begin
          if (rem_sh >= dvs_ext) begin
            rem_d = rem_sh - dvs_ext;
            quo_d = {quo_q[AW-2:0], 1'b1};
          end else begin
            rem_d = rem_sh;
            quo_d = {quo_q[AW-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(AW-1)) begin
            div_run_d = 1'b0;
            state_d   = S_FIX;
          end
        end
      end
      S_FIX: begin
        lower_d = fix_lo;
        upper_d = fix_up;
        empty_d = fix_emp;
`ifdef SOLVER_CURRENT_OK_EN
        ok_d    = !fix_emp && (y_k >= fix_lo) && (y_k <= fix_up);
`endif
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q   <= S_IDLE;
      // NOTE: the operand arrays are tiny register files and are reset like every other flop, keeping the block X-free.
      a_q       <= '{default: '0};
      y_q       <= '{default: '0};
      k_q       <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      div_run_q <= 1'b0;
      acc_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      lower_q   <= '0;
      upper_q   <= '0;
      empty_q   <= 1'b0;
`ifdef SOLVER_CURRENT_OK_EN
      ok_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      a_q       <= a_d;
      y_q       <= y_d;
      k_q       <= k_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      div_run_q <= div_run_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      lower_q   <= lower_d;
      upper_q   <= upper_d;
      empty_q   <= empty_d;
`ifdef SOLVER_CURRENT_OK_EN
      ok_q      <= ok_d;
`endif
    end
  end

  assign bus.out_lower = lower_q;
  assign bus.out_upper = upper_q;
  assign bus.out_empty = empty_q;
  assign bus.out_busy  = (state_q == S_ACCUM) || (state_q == S_DIVIDE) || (state_q == S_FIX);
  assign bus.out_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_variable_bound_solver.sv
// ---------------------------------------------------------------------------
// tb_variable_bound_solver
//   Drives variable_bound_solver at its default parameters. A reference model
//   solves each accepted clause by scanning every WIDTH-bit value of y_k and
//   keeping the satisfying ones; a timing model tracks the accept/busy/done
//   window. One negedge process compares the DUT against both every cycle.
//   Directed cases carry hand-computed literals that also pin the model.
// ---------------------------------------------------------------------------
module tb_variable_bound_solver;
  localparam int NV   = 2;
  localparam int W    = 8;
  localparam int IW   = 1;
  localparam int AWB  = 2*W + $clog2(NV+1);
  localparam int MINV = -(2**(W-1));
  localparam int MAXV = 2**(W-1) - 1;

  logic in_clk;
  logic in_reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  variable_bound_solver_if #(.NUM_VARS(NV), .WIDTH(W), .IDX_W(IW)) bus ();

  variable_bound_solver #(.NUM_VARS(NV), .WIDTH(W), .IDX_W(IW)) dut (
    .in_clk   (in_clk),
    .in_reset (in_reset),
    .bus      (bus)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: interval of y_k found by exhaustive scan over the value range.
  function automatic void ref_solve(input logic [(NV+1)*W-1:0] c, input logic [NV*W-1:0] y,
                                    input int k, output int lo, output int up,
                                    output bit emp, output bit ok, output int lat);
    int r, ak, yk;
    bit found;
    lo = MAXV; up = MINV; emp = 1'b1; ok = 1'b0; found = 1'b0; lat = 1;
    if (k >= NV) return;
    r = int'($signed(c[NV*W +: W]));
    for (int i = 0; i < NV; i++)
      if (i != k) r += int'($signed(c[i*W +: W])) * int'($signed(y[i*W +: W]));
    ak  = int'($signed(c[k*W +: W]));
    yk  = int'($signed(y[k*W +: W]));
    lat = (ak == 0) ? NV + 2 : NV + AWB + 2;
    for (int v = MINV; v <= MAXV; v++)
      if (ak*v + r <= 0) begin
        if (!found) lo = v;
        up    = v;
        found = 1'b1;
      end
    emp = !found;
    if (emp) begin lo = MAXV; up = MINV; end
    ok = (ak*yk + r <= 0);
  endfunction

  // Timing/output model: active from the accept edge through the done cycle.
  bit m_active;
  int m_rem, m_lower, m_upper;
  bit m_empty, m_ok;
  int e_lo, e_up, e_lat;
  bit e_emp, e_ok;

  always @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      m_active <= 1'b0; m_rem <= 0;
      m_lower <= 0; m_upper <= 0; m_empty <= 1'b0; m_ok <= 1'b0;
    end else if (!m_active) begin
      if (bus.in_start) begin
        ref_solve(bus.in_coefficients, bus.in_current_assignment, int'(bus.in_var_index),
                  e_lo, e_up, e_emp, e_ok, e_lat);
        m_active <= 1'b1;
        m_rem    <= e_lat;
      end
    end else if (m_rem == 0) begin
      m_active <= 1'b0;
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_lower <= e_lo; m_upper <= e_up; m_empty <= e_emp; m_ok <= e_ok && !e_emp;
      end
    end
  end

  always @(negedge in_clk) begin
    if (in_reset) begin
      check("done",  bus.out_done, longint'(m_active && m_rem == 0));
      check("busy",  bus.out_busy, longint'(m_active && m_rem != 0));
      check("lower", $signed(bus.out_lower), m_lower);
      check("upper", $signed(bus.out_upper), m_upper);
      check("empty", bus.out_empty, m_empty);
`ifdef SOLVER_CURRENT_OK_EN
      check("current_ok", bus.out_current_ok, m_ok);
`endif
    end
  end

  function automatic logic [W-1:0] rbyte();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'h80;
      2:       return 8'h7f;
      3:       return 8'h01;
      4:       return 8'hff;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic scramble();
    bus.in_coefficients       = {rbyte(), rbyte(), rbyte()};
    bus.in_current_assignment = {rbyte(), rbyte()};
    bus.in_var_index          = IW'($urandom_range(0, NV-1));
  endtask

  function automatic logic [(NV+1)*W-1:0] pk_c(input int a0, input int a1, input int an);
    return {W'(an), W'(a1), W'(a0)};
  endfunction

  function automatic logic [NV*W-1:0] pk_y(input int y0, input int y1);
    return {W'(y1), W'(y0)};
  endfunction

  // Directed solve: literals pin both the model and the DUT.
  task automatic run_case(input string name, input logic [(NV+1)*W-1:0] c,
                          input logic [NV*W-1:0] y, input int k, input int lo,
                          input int up, input bit emp, input bit ok, input int lat,
                          input bit poke);
    int mlo, mup, mlat, t0, w;
    bit memp, mok, got;
    ref_solve(c, y, k, mlo, mup, memp, mok, mlat);
    check({name, " model lower"}, mlo, lo);
    check({name, " model upper"}, mup, up);
    check({name, " model empty"}, memp, emp);
    check({name, " model latency"}, mlat, lat);
    @(posedge in_clk); #1;
    w = 0;
    while (m_active && w < 100) begin @(posedge in_clk); #1; w++; end
    check({name, " idle wait"}, longint'(m_active), 0);
    bus.in_start = 1'b1;
    bus.in_coefficients = c;
    bus.in_current_assignment = y;
    bus.in_var_index = IW'(k);
    @(posedge in_clk); #1;
    t0 = cyc;
    bus.in_start = 1'b0;
    scramble();
    if (poke) begin
      repeat (5) begin @(posedge in_clk); #1; end
      bus.in_start = 1'b1;
      @(posedge in_clk); #1;
      bus.in_start = 1'b0;
    end
    got = 1'b0; w = 0;
    while (!got && w < 100) begin
      @(negedge in_clk);
      if (bus.out_done) got = 1'b1; else w++;
    end
    check({name, " done seen"}, got, 1);
    check({name, " latency"}, cyc - t0, lat);
    check({name, " lower"}, $signed(bus.out_lower), lo);
    check({name, " upper"}, $signed(bus.out_upper), up);
    check({name, " empty"}, bus.out_empty, emp);
`ifdef SOLVER_CURRENT_OK_EN
    check({name, " current_ok"}, bus.out_current_ok, ok);
`else
    if (ok && !mok) check({name, " model ok"}, mok, ok);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    in_reset = 1'b0;
    bus.in_start = 1'b0;
    bus.in_coefficients = '0;
    bus.in_current_assignment = '0;
    bus.in_var_index = '0;
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    check("reset lower", bus.out_lower, 0);
    check("reset upper", bus.out_upper, 0);
    check("reset empty", bus.out_empty, 0);
    check("reset busy",  bus.out_busy, 0);
    check("reset done",  bus.out_done, 0);
    in_reset = 1'b1;

    run_case("r-6 y0=2", pk_c(3, 2, -10), pk_y(2, 2), 0, -128, 2, 0, 1, 22, 0);
    run_case("r-6 y0=3", pk_c(3, 2, -10), pk_y(3, 2), 0, -128, 2, 0, 0, 22, 1);
    run_case("neg ak",   pk_c(-4, 1, 5), pk_y(0, 3), 0, 2, 127, 0, 0, 22, 0);
    run_case("floor",    pk_c(3, 0, 7), pk_y(-3, 55), 0, -128, -3, 0, 1, 22, 0);
    run_case("ak0 sat",  pk_c(0, 1, -5), pk_y(17, 2), 0, -128, 127, 0, 1, 4, 0);
    run_case("ak0 unsat",pk_c(0, 1, -5), pk_y(17, 9), 0, 127, -128, 1, 0, 4, 0);
    run_case("clamp hi", pk_c(1, 100, 0), pk_y(5, -100), 0, -128, 127, 0, 1, 22, 0);
    run_case("empty lo", pk_c(1, 100, 0), pk_y(5, 100), 0, 127, -128, 1, 0, 22, 0);
    run_case("k=1 ceil", pk_c(5, -7, 3), pk_y(4, 10), 1, 4, 127, 0, 1, 22, 0);

    // Reset in the middle of a solve: outputs clear at once, no done pulse.
    @(posedge in_clk); #1;
    bus.in_start = 1'b1;
    bus.in_coefficients = pk_c(3, 2, -10);
    bus.in_current_assignment = pk_y(2, 2);
    bus.in_var_index = '0;
    @(posedge in_clk); #1;
    bus.in_start = 1'b0;
    repeat (10) begin @(posedge in_clk); #1; end
    #2 in_reset = 1'b0;
    #1;
    check("midreset lower", bus.out_lower, 0);
    check("midreset upper", bus.out_upper, 0);
    check("midreset empty", bus.out_empty, 0);
    check("midreset busy",  bus.out_busy, 0);
    check("midreset done",  bus.out_done, 0);
    @(negedge in_clk);
    in_reset = 1'b1;
    dones = 0;
    repeat (40) begin @(negedge in_clk); if (bus.out_done) dones++; end
    check("midreset no done", dones, 0);

    // Random traffic: starts at any time, operands changing every cycle.
    repeat (3000) begin
      @(posedge in_clk); #1;
      scramble();
      bus.in_start = ($urandom_range(0, 2) == 0);
    end
    bus.in_start = 1'b0;
    repeat (60) @(posedge in_clk);
    @(negedge in_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
